// File: rtl/sensor_seq_pkg.sv
// sensor_seq_pkg: shared state enum, sensor mode codes and a
// small width helper for the sensor mode sequencer.
package sensor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POWER_UP,
    WAIT_READY,
    DWELL,
    RETRY_OFF,
    DONE,
    FAULT
  } seq_state_e;

  localparam logic [1:0] MODE_STANDBY = 2'd0;
  localparam logic [1:0] MODE_INIT    = 2'd1;
  localparam logic [1:0] MODE_STREAM  = 2'd2;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_mode_sequencer_if.sv
// sensor_mode_sequencer_if: link between the sequencer and the
// sensor controller (mode/power out, status back).
interface sensor_mode_sequencer_if;
  logic [1:0] mode;
  logic       power_enable;
  logic       ready;
  logic       model_err;
  logic       nack_err;

  modport master (
    output mode, power_enable,
    input  ready, model_err, nack_err
  );

  modport slave (
    input  mode, power_enable,
    output ready, model_err, nack_err
  );
endinterface

// File: rtl/sensor_mode_sequencer_timer.sv
// seq_timer: loadable saturating down-counter; last_o flags the
// final cycle of a loaded interval (a load of 0 never expires).
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // load a new interval or count the current one down to zero
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/sensor_mode_sequencer.sv
// sensor_mode_sequencer: walks a sensor through a mode/dwell table
// with retry and fault handling; SEQ_LOOP_EN wraps the table forever.
module sensor_mode_sequencer
  import sensor_seq_pkg::*;
#(
  parameter int NUM_STEPS        = 4,
  parameter int DWELL_WIDTH      = 26,
  parameter int READY_TIMEOUT    = 48000000,
  parameter int POWER_OFF_CYCLES = 480000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                               clk_in,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               skip,
  input  logic [2*NUM_STEPS-1:0]             step_modes,
  input  logic [DWELL_WIDTH*NUM_STEPS-1:0]   step_dwell,
  sensor_mode_sequencer_if.master            sns,
  output logic [$clog2(NUM_STEPS)-1:0]       step_index,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic                               busy,
  output logic                               done,
  output logic                               fault
);

  localparam int IW = $clog2(NUM_STEPS);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = max3(DWELL_WIDTH,
                           $clog2(READY_TIMEOUT + 1),
                           $clog2(POWER_OFF_CYCLES + 1));

  localparam logic [IW-1:0] LAST    = IW'(NUM_STEPS - 1);
  localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRIES);
  localparam logic [TW-1:0] T_READY = TW'(READY_TIMEOUT);
  localparam logic [TW-1:0] T_OFF   = TW'(POWER_OFF_CYCLES);

  seq_state_e             state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic                   pwr_q, pwr_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [RW-1:0]          rty_q, rty_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fault_q, fault_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_last;

  logic                   fault_ev, retry_ev, adv_ev, go_wait;
  logic [IW-1:0]          ent_idx;
  logic [1:0]             ent_mode;
  logic [DWELL_WIDTH-1:0] ent_dwell;

  seq_timer #(.W(TW)) u_timer (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .val_i   (tmr_val),
    .last_o  (tmr_last)
  );

  // step being entered: next entry after a dwell, else step 0
  assign ent_idx   = (state_q == DWELL && idx_q != LAST)
                   ? idx_q + 1'b1 : '0;
  assign ent_mode  = step_modes[2*int'(ent_idx) +: 2];
  assign ent_dwell = step_dwell[DWELL_WIDTH*int'(ent_idx) +: DWELL_WIDTH];

  // next-state and next-output decode with abort > fault > retry > advance
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pwr_d    = pwr_q;
    idx_d    = idx_q;
    rty_d    = rty_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fault_d  = fault_q;
    dwell_d  = dwell_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    fault_ev = 1'b0;
    retry_ev = 1'b0;
    adv_ev   = 1'b0;
    go_wait  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      mode_d  = MODE_STANDBY;
      pwr_d   = 1'b0;
      idx_d   = '0;
      rty_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = POWER_UP;
            mode_d  = MODE_STANDBY;
            pwr_d   = 1'b1;
            idx_d   = '0;
            rty_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        POWER_UP: go_wait = 1'b1;
        WAIT_READY: begin
          done_d = 1'b0;
          if (sns.model_err) begin
            fault_ev = 1'b1;
          end else if (sns.nack_err || (!sns.ready && tmr_last)) begin
            retry_ev = 1'b1;
          end else if (sns.ready) begin
            state_d  = DWELL;
            tmr_load = 1'b1;
            tmr_val  = TW'(dwell_q);
          end
        end
        DWELL: begin
          if (sns.model_err) begin
            fault_ev = 1'b1;
          end else if (sns.nack_err) begin
            retry_ev = 1'b1;
          end else if (skip || tmr_last) begin
            adv_ev = 1'b1;
          end
        end
        RETRY_OFF: begin
          if (tmr_last) begin
            state_d = POWER_UP;
            pwr_d   = 1'b1;
            idx_d   = '0;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase

      if (fault_ev || (retry_ev && rty_q == RMAX)) begin
        state_d = FAULT;
        fault_d = 1'b1;
        mode_d  = MODE_STANDBY;
        pwr_d   = 1'b0;
        busy_d  = 1'b0;
      end else if (retry_ev) begin
        state_d  = RETRY_OFF;
        rty_d    = rty_q + 1'b1;
        idx_d    = '0;
        mode_d   = MODE_STANDBY;
        pwr_d    = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = T_OFF;
      end else if (adv_ev) begin
        if (idx_q == LAST) begin
`ifdef SEQ_LOOP_EN
          idx_d   = '0;
          done_d  = 1'b1;
          go_wait = 1'b1;
`else
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          go_wait = 1'b1;
        end
      end

      if (go_wait) begin
        state_d  = WAIT_READY;
        mode_d   = ent_mode;
        dwell_d  = ent_dwell;
        tmr_load = 1'b1;
        tmr_val  = T_READY;
      end
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_STANDBY;
      pwr_q   <= 1'b0;
      idx_q   <= '0;
      rty_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pwr_q   <= pwr_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      dwell_q <= dwell_d;
    end
  end

  assign sns.mode         = mode_q;
  assign sns.power_enable = pwr_q;
  assign step_index       = idx_q;
  assign retry_count      = rty_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fault            = fault_q;

endmodule
